// File: rtl/mimo_frame_ctrl.sv
// Frame controller between a tagged word stream and MIMO_detector.
// Optional: define MIMO_FRAME_PERF_EN for the per-frame cycle counter.
module mimo_frame_ctrl #(
  parameter int N_ANT      = 4,
  parameter int INT_W      = 6,
  parameter int FRAC_W     = 10,
  parameter int SYM_W      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8,
  localparam int W  = 2 * N_ANT * (INT_W + FRAC_W),
  localparam int DW = N_ANT * SYM_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_flag,
  input  logic             s_last,
  input  logic [W-1:0]     s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_flag,
  output logic [W-1:0]     m_data,
  input  logic             d_valid,
  input  logic [DW-1:0]    d_data,
  output logic             o_valid,
  output logic [DW-1:0]    o_data,
  output logic             o_last,
  output logic             err_seq,
  output logic             err_unexp,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [31:0]      perf_cycles
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(N_ANT + 1);

  typedef enum logic [1:0] {
    IDLE, LOAD_H, LOAD_Y, DRAIN
  } state_t;

  state_t state, state_nx;

  logic [W:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fill;
  logic [RW-1:0]    rows, rows_nx;
  logic [CNT_W-1:0] outst, outst_nx;
  logic full, empty, acc, push, pop;
  logic pop_data, seq_bad, fin;

  assign full     = fill == (AW+1)'(FIFO_DEPTH);
  assign empty    = fill == '0;
  assign s_ready  = !full && state != DRAIN;
  assign acc      = s_valid && s_ready;
  assign m_valid  = !empty;
  assign pop      = !empty && m_ready;
  assign pop_data = pop && !m_flag;
  assign fin      = d_valid && state == DRAIN
                 && empty && outst == CNT_W'(1);

  // Head entry is gated so the outputs read zero while empty.
  assign {m_flag, m_data} =
    empty ? {(W+1){1'b0}} : mem[rd_ptr];

  // Outstanding results: pops of data add, detector results retire.
  always_comb begin
    outst_nx = outst;
    if (pop_data && !d_valid)
      outst_nx = outst + CNT_W'(1);
    else if (d_valid && !pop_data && outst != '0)
      outst_nx = outst - CNT_W'(1);
  end

  // Frame ordering: decide push/drop and the next phase.
  always_comb begin
    state_nx = state;
    rows_nx  = rows;
    push     = 1'b0;
    seq_bad  = 1'b0;
    unique case (state)
      IDLE: if (acc) begin
        if (s_flag) begin
          push     = 1'b1;
          rows_nx  = RW'(1);
          state_nx = (N_ANT == 1) ? LOAD_Y : LOAD_H;
        end else begin
          seq_bad = 1'b1;
        end
      end
      LOAD_H: if (acc) begin
        if (s_flag) begin
          push    = 1'b1;
          rows_nx = rows + RW'(1);
          if (rows_nx == RW'(N_ANT))
            state_nx = LOAD_Y;
        end else begin
          seq_bad = 1'b1;
        end
      end
      LOAD_Y: if (acc) begin
        if (!s_flag) begin
          push = 1'b1;
          if (s_last)
            state_nx = DRAIN;
        end else begin
          seq_bad = 1'b1;
        end
      end
      DRAIN:
        if (empty && outst_nx == '0)
          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Phase and channel-row count registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      rows  <= '0;
    end else begin
      state <= state_nx;
      rows  <= rows_nx;
    end
  end

  // FIFO pointers and occupancy; reset discards the contents.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // FIFO storage keeps each word with its flag.
  always_ff @(posedge Clk) begin
    if (push)
      mem[wr_ptr] <= {s_flag, s_data};
  end

  // Result forwarding, frame completion and sticky errors.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      outst     <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_last    <= 1'b0;
      err_seq   <= 1'b0;
      err_unexp <= 1'b0;
      frame_cnt <= '0;
    end else begin
      outst   <= outst_nx;
      o_valid <= d_valid;
      o_data  <= d_data;
      o_last  <= fin;
      if (seq_bad)
        err_seq <= 1'b1;
      if (d_valid && outst == '0)
        err_unexp <= 1'b1;
      if (fin)
        frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

`ifdef MIMO_FRAME_PERF_EN
  logic [31:0] perf_cnt;

  // Cycles spent in a frame, latched when its last result leaves.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (state == IDLE) begin
        if (state_nx != IDLE)
          perf_cnt <= '0;
      end else begin
        perf_cnt <= perf_cnt + 32'd1;
      end
      if (fin)
        perf_cycles <= perf_cnt + 32'd1;
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule
